mux4_rr_arbiter: RTL

Round-robin arbiter that shares the 4:1 single-bit mux (mux_3_x_1) among four requesters.
Drives the mux select pair sel1/sel0 and a one-hot grant vector.
Bounds each tenure to HOLD_CYCLES clocks so no requester starves.
Sits directly in front of the mux; requester i owns mux input i while granted.

---
 rtl/mux_arb_pkg.sv | 19 +
 rtl/mux4_rr_arbiter_rr_pick.sv | 28 ++
 rtl/mux4_rr_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-requester round-robin mux arbiter.
package mux_arb_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request bit scanning from ptr upward, modulo 4.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    any   = |req;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ptr + SEL_W'(k);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter driving the 4:1 mux selects with bounded tenure.
// Define ARB_GRANT_CNT_EN to add the saturating grant_count output.
module mux4_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic             sel1,
  output logic             sel0,
  output logic             busy
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [7:0]       grant_count
`endif
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;

  logic [SEL_W-1:0] pick_ptr;
  logic             pick_any;
  logic [SEL_W-1:0] pick_idx;
  logic             release_w;
  logic             new_grant;

  // sel_q doubles as the owner index; during a tenure the scan starts just past
  // the owner so the owner itself is considered last on re-arbitration.
  assign pick_ptr  = (state_q == GRANT) ? sel_q + 2'd1 : ptr_q;
  assign release_w = (state_q == GRANT) && (!req[sel_q] || (cnt_q == '0));

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    new_grant = 1'b0;

    if (state_q == IDLE) begin
      if (pick_any) new_grant = 1'b1;
    end else if (release_w) begin
      ptr_d = pick_ptr;
      if (pick_any) begin
        new_grant = 1'b1;
      end else begin
        // sel keeps its last value so the mux input does not glitch.
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
    end

    if (new_grant) begin
      state_d = GRANT;
      grant_d = onehot(pick_idx);
      sel_d   = pick_idx;
      busy_d  = 1'b1;
      cnt_d   = HOLD_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

  assign grant = grant_q;
  assign sel1  = sel_q[1];
  assign sel0  = sel_q[0];
  assign busy  = busy_q;

`ifdef ARB_GRANT_CNT_EN
  logic [7:0] gcnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      gcnt_q <= '0;
    end else if (new_grant && (gcnt_q != 8'hFF)) begin
      gcnt_q <= gcnt_q + 8'd1;
    end
  end

  assign grant_count = gcnt_q;
`endif

endmodule
